// File: rtl/vx_hpdcache_rsp_buffer.sv
// vx_hpdcache_rsp_buffer: credit-gated response FIFO and flush fence in front of the HPDCache adapter.
// Define VX_HPDC_RSP_BYPASS_EN for a zero-latency hpd_rsp -> core_rsp path when the FIFO is empty.
module vx_hpdcache_rsp_buffer #(
  parameter int RSP_DEPTH  = 4,
  parameter int DATA_WIDTH = 128,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_req_valid,
  input  logic                           in_req_rw,
  input  logic                           in_req_flush,
  input  logic [TAG_WIDTH-1:0]           in_req_tag,
  output logic                           in_req_ready,
  output logic                           out_req_valid,
  input  logic                           out_req_ready,
  input  logic                           hpd_rsp_valid,
  input  logic [DATA_WIDTH-1:0]          hpd_rsp_data,
  input  logic [TAG_WIDTH-1:0]           hpd_rsp_tag,
  output logic                           core_rsp_valid,
  input  logic                           core_rsp_ready,
  output logic [DATA_WIDTH-1:0]          core_rsp_data,
  output logic [TAG_WIDTH-1:0]           core_rsp_tag,
  output logic [$clog2(RSP_DEPTH+1)-1:0] credits_o,
  output logic                           flush_busy_o,
  output logic                           err_overflow_o
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH+1);
  typedef enum logic [1:0] {IDLE, DRAIN, FENCE} state_t;
  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_credits;
  logic [TAG_WIDTH-1:0]  r_flush_tag;
  logic [PW:0]           r_wr_ptr, r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_data [RSP_DEPTH];
  logic [TAG_WIDTH-1:0]  r_tag [RSP_DEPTH];
  logic                  r_err;
  logic w_needs_rsp, w_allow, w_req_hs, w_rsp_hs, w_empty, w_full, w_push, w_pop, w_byp;

  assign w_needs_rsp = in_req_flush | ~in_req_rw;
  always_comb begin
    w_allow = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        w_allow = ~in_req_flush & (~w_needs_rsp | (r_credits != '0));
        if (in_req_valid & in_req_flush) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_allow = in_req_flush & (r_credits == CW'(RSP_DEPTH));
        if (in_req_valid & out_req_ready & w_allow) w_state_nxt = FENCE;
      end
      FENCE: if (w_rsp_hs & (core_rsp_tag == r_flush_tag)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign out_req_valid = in_req_valid & w_allow;
  assign in_req_ready  = out_req_ready & w_allow;
  assign w_req_hs      = in_req_valid & in_req_ready;

`ifdef VX_HPDC_RSP_BYPASS_EN
  assign w_byp = w_empty & core_rsp_ready & hpd_rsp_valid;
`else
  assign w_byp = 1'b0;
`endif
  assign w_empty        = r_wr_ptr == r_rd_ptr;
  assign w_full         = (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]) & (r_wr_ptr[PW] != r_rd_ptr[PW]);
  assign core_rsp_valid = ~w_empty | w_byp;
  assign core_rsp_data  = ~w_empty ? r_data[r_rd_ptr[PW-1:0]] : w_byp ? hpd_rsp_data : '0;
  assign core_rsp_tag   = ~w_empty ? r_tag[r_rd_ptr[PW-1:0]] : w_byp ? hpd_rsp_tag : '0;
  assign w_rsp_hs       = core_rsp_valid & core_rsp_ready;
  assign w_pop          = w_rsp_hs & ~w_empty;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO is still legal then.
  assign w_push         = hpd_rsp_valid & ~w_byp & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr_ptr[PW-1:0]] <= hpd_rsp_data;
      r_tag[r_wr_ptr[PW-1:0]]  <= hpd_rsp_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_credits   <= CW'(RSP_DEPTH);
      r_flush_tag <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_credits <= r_credits - CW'(w_req_hs & w_needs_rsp) + CW'(w_rsp_hs);
      if (r_state == DRAIN && w_req_hs) r_flush_tag <= in_req_tag;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (hpd_rsp_valid & ~w_byp & ~w_push) r_err <= 1'b1;
    end
  end

  assign credits_o      = r_credits;
  assign flush_busy_o   = r_state != IDLE;
  assign err_overflow_o = r_err;
endmodule

// File: tb/tb_vx_hpdcache_rsp_buffer.sv
// tb_vx_hpdcache_rsp_buffer: directed scenarios plus randomized traffic against a queue-based model.
module tb_vx_hpdcache_rsp_buffer;
  localparam int DEPTH = 4;
`ifdef VX_HPDC_RSP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0, reset_n = 0;
  logic in_req_valid = 0, in_req_rw = 0, in_req_flush = 0, in_req_ready, out_req_valid, out_req_ready = 0;
  logic [7:0] in_req_tag = 0, hpd_rsp_tag = 0, core_rsp_tag;
  logic hpd_rsp_valid = 0, core_rsp_valid, core_rsp_ready = 0;
  logic [127:0] hpd_rsp_data = 0, core_rsp_data;
  logic [2:0] credits_o;
  logic flush_busy_o, err_overflow_o;

  vx_hpdcache_rsp_buffer #(.RSP_DEPTH(DEPTH), .DATA_WIDTH(128), .TAG_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_req_valid(in_req_valid), .in_req_rw(in_req_rw),
    .in_req_flush(in_req_flush), .in_req_tag(in_req_tag), .in_req_ready(in_req_ready),
    .out_req_valid(out_req_valid), .out_req_ready(out_req_ready), .hpd_rsp_valid(hpd_rsp_valid),
    .hpd_rsp_data(hpd_rsp_data), .hpd_rsp_tag(hpd_rsp_tag), .core_rsp_valid(core_rsp_valid),
    .core_rsp_ready(core_rsp_ready), .core_rsp_data(core_rsp_data), .core_rsp_tag(core_rsp_tag),
    .credits_o(credits_o), .flush_busy_o(flush_busy_o), .err_overflow_o(err_overflow_o));

  always #5 clk = ~clk;

  // Model: responses owed by HPDCache (outq) and responses buffered for the core (q).
  // Free credits follow from the invariant credits = DEPTH - outstanding - buffered.
  typedef struct {logic [127:0] d; logic [7:0] t;} rsp_t;
  rsp_t q[$];
  logic [7:0] outq[$];
  int m_mode;
  logic [7:0] m_ftag;
  bit m_err;
  int nchk = 0, nerr = 0;
  bit d_in_ready, d_out_valid, d_core_valid, e_in_ready, e_out_valid, e_core_valid;
  logic [7:0] d_core_tag, e_core_tag;
  logic [127:0] d_core_data, e_core_data;

  function automatic int m_cred();
    return DEPTH - outq.size() - q.size();
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    {in_req_valid, in_req_rw, in_req_flush, out_req_ready, hpd_rsp_valid, core_rsp_ready} = '0;
    q.delete(); outq.delete(); m_mode = 0; m_err = 0; m_ftag = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic step(input bit v, input bit rw, input bit fl, input logic [7:0] tg, input bit ordy,
                      input bit hv, input logic [127:0] hd, input bit crdy);
    rsp_t r;
    bit allow, needs, req_hs, rsp_hs, byp;
    int cr, nm;
    @(negedge clk);
    in_req_valid = v; in_req_rw = rw; in_req_flush = fl; in_req_tag = tg; out_req_ready = ordy;
    hpd_rsp_valid = hv; hpd_rsp_data = hd; hpd_rsp_tag = outq.size() > 0 ? outq[0] : 8'hEE;
    core_rsp_ready = crdy;
    #1;
    d_in_ready = in_req_ready; d_out_valid = out_req_valid; d_core_valid = core_rsp_valid;
    d_core_tag = core_rsp_tag; d_core_data = core_rsp_data;
    cr = m_cred();
    needs = fl | ~rw;
    allow = m_mode == 2 ? 1'b0 : m_mode == 1 ? (fl && cr == DEPTH) : (!fl && (!needs || cr > 0));
    e_out_valid = v & allow;
    e_in_ready = ordy & allow;
    byp = BYP && q.size() == 0 && crdy && hv;
    e_core_valid = q.size() > 0 || byp;
    e_core_tag = q.size() > 0 ? q[0].t : byp ? hpd_rsp_tag : 8'h0;
    e_core_data = q.size() > 0 ? q[0].d : byp ? hd : 128'h0;
    req_hs = v & ordy & allow;
    rsp_hs = e_core_valid & crdy;
    @(posedge clk);
    nm = m_mode;
    if (m_mode == 0 && v && fl) nm = 1;
    if (m_mode == 1 && req_hs) begin nm = 2; m_ftag = tg; end
    if (m_mode == 2 && rsp_hs && e_core_tag == m_ftag) nm = 0;
    m_mode = nm;
    if (rsp_hs && q.size() > 0) void'(q.pop_front());
    if (hv) begin
      r.d = hd;
      r.t = hpd_rsp_tag;
      if (outq.size() > 0) void'(outq.pop_front());
      if (!byp) begin
        if (q.size() < DEPTH) q.push_back(r);
        else m_err = 1;
      end
    end
    if (req_hs && needs) outq.push_back(tg);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (outq.size() > 0 || q.size() > 0); i++)
      step(0, 0, 0, 0, 0, outq.size() > 0, rnd128(), 1);
    nchk++;
    if (outq.size() > 0 || q.size() > 0) begin
      nerr++; $display("FAIL drain_timeout: pending %0d/%0d required 0/0", outq.size(), q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    nchk += 6;
    if (credits_o !== 3'd4) begin nerr++; $display("FAIL rst_credits: got %0d exp 4", credits_o); end
    if (core_rsp_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b exp 0", core_rsp_valid); end
    if (core_rsp_data !== 128'h0 || core_rsp_tag !== 8'h0) begin nerr++; $display("FAIL rst_payload: got %h/%h exp 0", core_rsp_data, core_rsp_tag); end
    if (flush_busy_o !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b exp 0", flush_busy_o); end
    if (err_overflow_o !== 1'b0) begin nerr++; $display("FAIL rst_err: got %b exp 0", err_overflow_o); end
    if (in_req_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready: got %b exp 0", in_req_ready); end
    @(negedge clk) reset_n = 1;
  endtask

  task automatic test_credit_stall();
    int acc = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 8'(i + 1), 1, 0, 0, 0);
      acc += int'(d_in_ready);
      nchk++;
      if (d_in_ready !== e_in_ready) begin nerr++; $display("FAIL stall_ready%0d: got %b exp %b", i, d_in_ready, e_in_ready); end
    end
    #1;
    nchk += 3;
    if (acc != 4) begin nerr++; $display("FAIL stall_accepted: got %0d exp 4", acc); end
    if (d_in_ready !== 1'b0) begin nerr++; $display("FAIL stall_fifth: got %b exp 0", d_in_ready); end
    if (credits_o !== 3'd0) begin nerr++; $display("FAIL stall_credits: got %0d exp 0", credits_o); end
    step(1, 1, 0, 8'h99, 1, 0, 0, 0);
    #1;
    nchk += 2;
    if (d_in_ready !== 1'b1) begin nerr++; $display("FAIL store_bypass: got %b exp 1", d_in_ready); end
    if (credits_o !== 3'd0) begin nerr++; $display("FAIL store_credits: got %0d exp 0", credits_o); end
  endtask

  task automatic test_order();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, rnd128(), 0);
    #1;
    nchk++;
    if (core_rsp_valid !== 1'b1 || credits_o !== 3'd0) begin nerr++; $display("FAIL order_fill: got v=%b cr=%0d exp v=1 cr=0", core_rsp_valid, credits_o); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1);
      nchk += 2;
      if (d_core_valid !== 1'b1 || d_core_tag !== 8'(i + 1)) begin nerr++; $display("FAIL order_tag%0d: got v=%b t=%h exp v=1 t=%h", i, d_core_valid, d_core_tag, 8'(i + 1)); end
      if (d_core_data !== e_core_data) begin nerr++; $display("FAIL order_data%0d: got %h exp %h", i, d_core_data, e_core_data); end
    end
    #1;
    nchk++;
    if (credits_o !== 3'd4) begin nerr++; $display("FAIL order_credits: got %0d exp 4", credits_o); end
    step(1, 0, 0, 8'h05, 1, 0, 0, 0);
    nchk++;
    if (d_in_ready !== 1'b1) begin nerr++; $display("FAIL order_fifth: got %b exp 1", d_in_ready); end
    drain();
  endtask

  task automatic test_latency();
    step(1, 0, 0, 8'h30, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, rnd128(), 1);
    nchk += 2;
    if (d_core_valid !== BYP || d_core_valid !== e_core_valid) begin nerr++; $display("FAIL lat_same: got %b exp %b", d_core_valid, BYP); end
    #1;
    if (core_rsp_valid !== !BYP) begin nerr++; $display("FAIL lat_next: got %b exp %b", core_rsp_valid, !BYP); end
    drain();
  endtask

  task automatic test_concurrent();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'h41 + i), 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, rnd128(), 0);
    #1;
    nchk++;
    if (credits_o !== 3'd1) begin nerr++; $display("FAIL conc_pre: got %0d exp 1", credits_o); end
    step(1, 0, 0, 8'h44, 1, 0, 0, 1);
    #1;
    nchk += 2;
    if (d_in_ready !== 1'b1 || d_core_valid !== 1'b1) begin nerr++; $display("FAIL conc_hs: got r=%b v=%b exp 1/1", d_in_ready, d_core_valid); end
    if (credits_o !== 3'd1 || m_cred() != 1) begin nerr++; $display("FAIL conc_credits: got %0d exp 1", credits_o); end
    drain();
  endtask

  task automatic test_flush();
    bit acc = 0;
    step(1, 0, 0, 8'h21, 1, 0, 0, 0);
    step(1, 0, 0, 8'h22, 1, 0, 0, 0);
    step(1, 0, 1, 8'h7F, 1, 0, 0, 0);
    #1;
    nchk += 2;
    if (d_in_ready !== 1'b0) begin nerr++; $display("FAIL flush_idle_ready: got %b exp 0", d_in_ready); end
    if (flush_busy_o !== 1'b1) begin nerr++; $display("FAIL flush_busy: got %b exp 1", flush_busy_o); end
    for (int i = 0; i < 10 && !acc; i++) begin
      step(1, 0, 1, 8'h7F, 1, outq.size() > 0, rnd128(), i >= 3);
      acc = d_in_ready;
      nchk++;
      if (d_out_valid !== e_out_valid || d_in_ready !== e_in_ready) begin nerr++; $display("FAIL flush_drain%0d: got v=%b r=%b exp v=%b r=%b", i, d_out_valid, d_in_ready, e_out_valid, e_in_ready); end
    end
    #1;
    nchk += 2;
    if (!acc) begin nerr++; $display("FAIL flush_issue: got 0 exp 1"); end
    if (flush_busy_o !== 1'b1) begin nerr++; $display("FAIL flush_fence: got %b exp 1", flush_busy_o); end
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 8'h33, 1, 0, 0, 1);
      nchk++;
      if (d_in_ready !== 1'b0) begin nerr++; $display("FAIL fence_hold%0d: got %b exp 0", i, d_in_ready); end
    end
    step(1, 1, 0, 8'h33, 1, 1, rnd128(), 0);
    step(1, 1, 0, 8'h33, 1, 0, 0, 1);
    #1;
    nchk += 3;
    if (d_core_tag !== 8'h7F) begin nerr++; $display("FAIL fence_tag: got %h exp 7f", d_core_tag); end
    if (d_in_ready !== 1'b0) begin nerr++; $display("FAIL fence_exit_ready: got %b exp 0", d_in_ready); end
    if (flush_busy_o !== 1'b0) begin nerr++; $display("FAIL fence_exit: got %b exp 0", flush_busy_o); end
    step(1, 1, 0, 8'h33, 1, 0, 0, 1);
    nchk++;
    if (d_in_ready !== 1'b1) begin nerr++; $display("FAIL fence_after: got %b exp 1", d_in_ready); end
  endtask

  task automatic test_overflow_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'h61 + i), 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, rnd128(), 0);
    step(0, 0, 0, 0, 0, 1, rnd128(), 0);
    #1;
    nchk += 2;
    if (err_overflow_o !== 1'b1 || !m_err) begin nerr++; $display("FAIL ovf_set: got %b exp 1", err_overflow_o); end
    if (q.size() != DEPTH) begin nerr++; $display("FAIL ovf_model: got %0d exp %0d", q.size(), DEPTH); end
    drain();
    #1;
    nchk++;
    if (err_overflow_o !== 1'b1 || credits_o !== 3'd4) begin nerr++; $display("FAIL ovf_sticky: got e=%b cr=%0d exp 1/4", err_overflow_o, credits_o); end
    step(1, 0, 1, 8'h55, 1, 0, 0, 0);
    step(1, 0, 1, 8'h55, 1, 0, 0, 0);
    #1;
    nchk++;
    if (d_in_ready !== 1'b1 || flush_busy_o !== 1'b1) begin nerr++; $display("FAIL rst_fence_entry: got r=%b b=%b exp 1/1", d_in_ready, flush_busy_o); end
    @(negedge clk);
    reset_n = 0;
    #1;
    nchk += 3;
    if (credits_o !== 3'd4 || flush_busy_o !== 1'b0) begin nerr++; $display("FAIL midrst_state: got cr=%0d b=%b exp 4/0", credits_o, flush_busy_o); end
    if (err_overflow_o !== 1'b0) begin nerr++; $display("FAIL midrst_err: got %b exp 0", err_overflow_o); end
    if (core_rsp_valid !== 1'b0 || core_rsp_tag !== 8'h0 || core_rsp_data !== 128'h0) begin nerr++; $display("FAIL midrst_rsp: got v=%b t=%h exp 0", core_rsp_valid, core_rsp_tag); end
    do_reset();
    @(negedge clk) reset_n = 1;
  endtask

  task automatic test_random();
    bit fl;
    for (int i = 0; i < 2000; i++) begin
      fl = m_mode == 1 ? ($urandom_range(1, 0) == 1) : ($urandom_range(15, 0) == 0);
      step($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, fl, 8'($urandom), $urandom_range(3, 0) != 0,
           outq.size() > 0 && $urandom_range(1, 0) == 1, rnd128(), $urandom_range(2, 0) != 0);
      nchk++;
      if (d_in_ready !== e_in_ready || d_out_valid !== e_out_valid) begin nerr++; $display("FAIL rnd_req%0d: got r=%b v=%b exp r=%b v=%b", i, d_in_ready, d_out_valid, e_in_ready, e_out_valid); end
      nchk++;
      if (d_core_valid !== e_core_valid || d_core_tag !== e_core_tag || d_core_data !== e_core_data) begin nerr++; $display("FAIL rnd_rsp%0d: got v=%b t=%h d=%h exp v=%b t=%h d=%h", i, d_core_valid, d_core_tag, d_core_data, e_core_valid, e_core_tag, e_core_data); end
      #1;
      nchk++;
      if (credits_o !== 3'(m_cred()) || flush_busy_o !== (m_mode != 0) || err_overflow_o !== m_err) begin nerr++; $display("FAIL rnd_state%0d: got cr=%0d b=%b e=%b exp cr=%0d b=%b e=%b", i, credits_o, flush_busy_o, err_overflow_o, m_cred(), m_mode != 0, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_credit_stall();
    test_order();
    test_latency();
    test_concurrent();
    test_flush();
    drain();
    test_overflow_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/vx_hpdcache_rsp_buffer.md
# vx_hpdcache_rsp_buffer

Credit-gated response buffer and flush fence between the Vortex core memory bus and the HPDCache core-interface adapter. HPDCache returns responses without backpressure, so the block admits a response-producing request (load or flush) only when a free buffer slot is reserved. Responses are queued in a FIFO and drained to the core with valid/ready. It also serialises flushes: prior responses drain, the flush issues alone, and later requests wait until the flush response retires.

## Interface
- RSP_DEPTH, 4: response FIFO entries and credit pool size; power of two, ≥2.
- DATA_WIDTH, 128: response data width (WORD_SIZE*8).
- TAG_WIDTH, 8: request/response tag width.
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_req_valid  in  1  core request valid.
- in_req_rw  in  1  1 = store (no response), 0 = load.
- in_req_flush  in  1  request is a flush (always needs a response).
- in_req_ready  out  1  core request accepted.
- out_req_valid  out  1  request valid toward adapter; payload routed around this block.
- out_req_ready  in  1  adapter ready (HPDCache req_ready).
- hpd_rsp_valid  in  1  HPDCache response valid; no ready exists.
- hpd_rsp_data  in  DATA_WIDTH  response data.
- hpd_rsp_tag  in  TAG_WIDTH  response tag.
- core_rsp_valid  out  1  response to core valid.
- core_rsp_ready  in  1  core accepts response.
- core_rsp_data  out  DATA_WIDTH  response data.
- core_rsp_tag  out  TAG_WIDTH  response tag.
- credits_o  out  $clog2(RSP_DEPTH+1)  free credits.
- flush_busy_o  out  1  FSM not IDLE.
- err_overflow_o  out  1  sticky: response arrived with FIFO full.

## Operation
- needs_rsp = in_req_flush | ~in_req_rw.
- Credit counter, reset RSP_DEPTH: −1 on a handshake with needs_rsp; +1 on a core response handshake; both in one cycle → unchanged. Invariant: credits + outstanding + FIFO occupancy = RSP_DEPTH.
- allow: IDLE and non-flush → needs_rsp ? credits≠0 : 1; stores bypass credit checks. Flush requests are never admitted from IDLE.
- out_req_valid = in_req_valid & allow; in_req_ready = out_req_ready & allow (combinational).
- FSM IDLE/DRAIN/FENCE:
  - IDLE→DRAIN when in_req_valid & in_req_flush; no request accepted.
  - DRAIN: allow = in_req_flush & credits==RSP_DEPTH; flush handshake → FENCE and consumes one credit.
  - FENCE: allow = 0; → IDLE on the core handshake of the response whose tag equals the registered flush tag.
- FIFO: push on hpd_rsp_valid; pop on core_rsp_valid & core_rsp_ready; read/write pointers $clog2(RSP_DEPTH) bits plus a wrap bit; full = pointer equal with differing wrap bit.
- Push while full (illegal, protocol violation): response dropped, err_overflow_o set until reset.
- Push and pop in the same cycle while full: the pop frees the slot and the push is accepted, so no error.

## Timing
- Reset (async assert, sync-deasserted externally): credits_o=RSP_DEPTH, FIFO empty, core_rsp_valid=0, core_rsp_data/tag=0, flush_busy_o=0, err_overflow_o=0, FSM IDLE, in_req_ready=0 until inputs qualify.
- Credits update the cycle after the handshake; allow uses the registered value.
- hpd_rsp → core_rsp_valid: 1 cycle (registered FIFO), unless bypassed (see Configuration).
- core_rsp_valid, once high, holds with data and tag stable until core_rsp_ready.
- DRAIN→FENCE and FENCE→IDLE take effect the next cycle; a request presented on the FENCE-exit cycle is not accepted until the following cycle.
- reset_n asserted mid-flush or with responses pending: all state is cleared, and late HPDCache responses after reset are the integrator's responsibility.

## Configuration
- VX_HPDC_RSP_BYPASS_EN defined: if the FIFO is empty and core_rsp_ready=1, hpd_rsp is driven combinationally to core_rsp_* in the same cycle without a push (0-cycle latency). Credits are released on that handshake.
- Undefined: every response is pushed; minimum latency is 1 cycle; no combinational path from hpd_rsp_* to core_rsp_*.

## Test plan
- RSP_DEPTH=4, 5 back-to-back loads, core_rsp_ready=0 → 4 accepted, 5th stalled (in_req_ready=0), credits_o=0; stores still accepted.
- Return 4 responses tags 1..4, then core_rsp_ready=1 → core sees tags 1,2,3,4 in order, credits_o back to 4, 5th load then accepted.
- 2 loads outstanding, then flush tag 0x7F → flush_busy_o=1, out_req_valid=0 until both responses popped; flush issues; a following store is held until tag 0x7F retires.
- Simultaneous load handshake and core response pop at credits_o=1 → credits_o stays 1.
- Inject hpd_rsp_valid with FIFO full and no pop → response dropped, err_overflow_o=1 and sticky; reset_n low mid-FENCE → all outputs at reset values.
- With VX_HPDC_RSP_BYPASS_EN, empty FIFO, ready=1 → core_rsp_valid same cycle as hpd_rsp_valid; without it, one cycle later.
